// File: rtl/spi_xfer_pkg.sv
// Shared types and width helpers for the SPI transfer scheduler.
//   state_t         : scheduler FSM states
//   idx_width       : bits needed for a requester index / round-robin pointer
//   bit_cnt_width   : bits needed to count 0..DWIDTH remaining bit periods
//   tick_cnt_width  : bits needed for the phase / chip-select gap counter
package spi_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic int idx_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int bit_cnt_width(input int dwidth);
    return $clog2(dwidth + 1);
  endfunction

  // Counter must hold both CLKDIV-1 (phase length) and CS_GAP (setup length).
  function automatic int tick_cnt_width(input int clkdiv, input int cs_gap);
    return (clkdiv > cs_gap) ? $clog2(clkdiv + 1) : $clog2(cs_gap + 1);
  endfunction

endpackage

// File: rtl/spi_xfer_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req : request vector
//   i_ptr : highest-priority index for this evaluation
//   i_en  : grants are produced only when high
//   o_gnt : one-hot grant (all zero when nothing wins)
//   o_idx : encoded index of the winner (0 when nothing wins)
module rr_arbiter
  import spi_xfer_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx
);

  logic          w_found;
  logic [IW-1:0] w_cand;

  // Scan from i_ptr upward, wrapping, and take the first requester found.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = IW'((int'(i_ptr) + k) % NREQ);
      if (i_en && !w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_sched.sv
// Shares one SPI bus (mode 0, MSB first) between NREQ requesters.
// One DWIDTH-bit full-duplex word is moved per grant; grants are round-robin.
//   axi_aclk / axi_aresetn : clock, asynchronous active-low reset
//   req_valid / req_data   : per-requester request and write word slice
//   req_ready              : one-cycle accept pulse to the granted requester
//   rsp_valid / rsp_data   : one-cycle completion pulse and received word
//   busy                   : high from grant until the completion cycle
//   spi_sclk/mosi/miso/cs_n: SPI bus, one chip select per requester
module spi_xfer_sched
  import spi_xfer_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 16,
  parameter int CLKDIV = 4,
  parameter int CS_GAP = 2
) (
  input  logic                     axi_aclk,
  input  logic                     axi_aresetn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DWIDTH-1:0]        rsp_data,
  output logic                     busy,
  output logic                     spi_sclk,
  output logic                     spi_mosi,
  input  logic                     spi_miso,
  output logic [NREQ-1:0]          spi_cs_n
);

  localparam int IW = idx_width(NREQ);
  localparam int BW = bit_cnt_width(DWIDTH);
  localparam int CW = tick_cnt_width(CLKDIV, CS_GAP);

  state_t              r_state, w_state_nxt;
  logic [IW-1:0]       r_ptr, w_ptr_nxt;
  logic [IW-1:0]       r_owner, w_owner_nxt;
  logic [DWIDTH-1:0]   r_shreg, w_shreg_nxt;
  logic [BW-1:0]       r_bit, w_bit_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic                r_sclk, w_sclk_nxt;
  logic                r_mosi, w_mosi_nxt;
  logic [NREQ-1:0]     r_cs_n, w_cs_n_nxt;
  logic [NREQ-1:0]     r_req_ready, w_req_ready_nxt;
  logic [NREQ-1:0]     r_rsp_valid, w_rsp_valid_nxt;
  logic [DWIDTH-1:0]   r_rsp_data, w_rsp_data_nxt;
  logic                r_busy, w_busy_nxt;

  logic [NREQ-1:0]     w_gnt;
  logic [IW-1:0]       w_gnt_idx;
  logic [DWIDTH-1:0]   w_word;
  logic [NREQ-1:0]     w_owner_oh;
  logic                w_arb_en;

  assign w_arb_en = (r_state == IDLE);
  assign w_word   = req_data[int'(w_gnt_idx)*DWIDTH +: DWIDTH];

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx)
  );

  // Decode the transfer owner for the completion pulse.
  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
  end

  // Next-state and next-output logic. SETUP lasts CS_GAP+1 cycles because
  // it includes the grant cycle; r_cnt==0 ends every timed phase.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_owner_nxt     = r_owner;
    w_shreg_nxt     = r_shreg;
    w_bit_nxt       = r_bit;
    w_cnt_nxt       = r_cnt;
    w_sclk_nxt      = r_sclk;
    w_mosi_nxt      = r_mosi;
    w_cs_n_nxt      = r_cs_n;
    w_busy_nxt      = r_busy;
    w_rsp_data_nxt  = r_rsp_data;
    w_req_ready_nxt = '0;
    w_rsp_valid_nxt = '0;
    case (r_state)
      IDLE: begin
        if (|w_gnt) begin
          w_state_nxt     = SETUP;
          w_req_ready_nxt = w_gnt;
          w_owner_nxt     = w_gnt_idx;
          w_ptr_nxt       = (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + IW'(1);
          w_shreg_nxt     = w_word;
          w_mosi_nxt      = w_word[DWIDTH-1];
          w_cs_n_nxt      = ~w_gnt;
          w_busy_nxt      = 1'b1;
          w_cnt_nxt       = CW'(CS_GAP);
          w_bit_nxt       = BW'(DWIDTH);
          w_sclk_nxt      = 1'b0;
        end else begin
          w_cs_n_nxt = '1;
          w_sclk_nxt = 1'b0;
          w_mosi_nxt = 1'b0;
          w_busy_nxt = 1'b0;
        end
      end
      SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = CW'(CLKDIV - 1);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      SHIFT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (!r_sclk) begin
          // Rising edge: capture miso into the LSB as the word shifts left.
          w_sclk_nxt  = 1'b1;
          w_shreg_nxt = {r_shreg[DWIDTH-2:0], spi_miso};
          w_bit_nxt   = r_bit - BW'(1);
          w_cnt_nxt   = CW'(CLKDIV - 1);
        end else if (r_bit == '0) begin
          // Falling edge after the last high phase: mosi is left untouched.
          w_sclk_nxt  = 1'b0;
          w_state_nxt = HOLD;
          w_cnt_nxt   = CW'(CS_GAP - 1);
        end else begin
          // Falling edge: the next transmit bit is now at the MSB.
          w_sclk_nxt = 1'b0;
          w_mosi_nxt = r_shreg[DWIDTH-1];
          w_cnt_nxt  = CW'(CLKDIV - 1);
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt     = DONE;
          w_cs_n_nxt      = '1;
          w_mosi_nxt      = 1'b0;
          w_busy_nxt      = 1'b0;
          w_rsp_valid_nxt = w_owner_oh;
          w_rsp_data_nxt  = r_shreg;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      DONE: begin
        // Guarantees at least one CS-high cycle before the next grant.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cs_n_nxt  = '1;
        w_sclk_nxt  = 1'b0;
        w_mosi_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset returns the bus and handshakes to idle.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_shreg     <= '0;
      r_bit       <= '0;
      r_cnt       <= '0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_cs_n      <= '1;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_shreg     <= w_shreg_nxt;
      r_bit       <= w_bit_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sclk      <= w_sclk_nxt;
      r_mosi      <= w_mosi_nxt;
      r_cs_n      <= w_cs_n_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;
  assign spi_sclk  = r_sclk;
  assign spi_mosi  = r_mosi;
  assign spi_cs_n  = r_cs_n;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Self-checking bench for spi_xfer_sched.
// Instance A: NREQ=4, DWIDTH=16, CLKDIV=4, CS_GAP=2 with a mode-0 slave model.
// Instance B: NREQ=4, DWIDTH=4, CLKDIV=1, CS_GAP=1 in loopback.
module tb_spi_xfer_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [3:0]  a_req_valid;
  logic [63:0] a_req_data;
  logic [3:0]  a_req_ready, a_rsp_valid, a_cs_n;
  logic [15:0] a_rsp_data;
  logic        a_busy, a_sclk, a_mosi, a_miso;

  logic [3:0]  b_req_valid;
  logic [15:0] b_req_data;
  logic [3:0]  b_req_ready, b_rsp_valid, b_cs_n;
  logic [3:0]  b_rsp_data;
  logic        b_busy, b_sclk, b_mosi, b_miso;

  spi_xfer_sched #(.NREQ(4), .DWIDTH(16), .CLKDIV(4), .CS_GAP(2)) u_dut_a (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .req_valid(a_req_valid), .req_data(a_req_data), .req_ready(a_req_ready),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .busy(a_busy),
    .spi_sclk(a_sclk), .spi_mosi(a_mosi), .spi_miso(a_miso), .spi_cs_n(a_cs_n)
  );

  spi_xfer_sched #(.NREQ(4), .DWIDTH(4), .CLKDIV(1), .CS_GAP(1)) u_dut_b (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .req_valid(b_req_valid), .req_data(b_req_data), .req_ready(b_req_ready),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .busy(b_busy),
    .spi_sclk(b_sclk), .spi_mosi(b_mosi), .spi_miso(b_miso), .spi_cs_n(b_cs_n)
  );

  // Slave model for A: captures mosi on sclk rise, serves slv_pat MSB first.
  logic        miso_sel;
  logic [15:0] slv_pat;
  logic [15:0] slv_rx = '0;
  int          slv_rise = 0;
  logic        a_cs_idle;
  assign a_cs_idle = &a_cs_n;

  always @(posedge a_sclk or posedge a_cs_idle) begin
    if (a_cs_idle) begin
      slv_rise <= 0;
    end else begin
      slv_rx   <= {slv_rx[14:0], a_mosi};
      slv_rise <= slv_rise + 1;
    end
  end

  assign a_miso = miso_sel ? ((slv_rise < 16) ? slv_pat[15 - slv_rise] : 1'b0) : a_mosi;
  assign b_miso = b_mosi;

  typedef struct {
    int          idx;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Watch one transfer on A from the current point until its completion pulse.
  task automatic observe_a(input bit auto_drop, output int g_idx, output int pre_high,
                           output int cs_len, output int rises, output int per_min,
                           output int per_max, output int rdy_cnt, output bit cs_ok,
                           output int r_idx, output logic [15:0] r_data,
                           output logic [15:0] s_rx, output bit timed_out);
    int   c;
    int   last_rise;
    logic prev_sclk;
    bit   done;
    g_idx = -1; pre_high = 0; cs_len = 0; rises = 0; per_min = 1000000; per_max = 0;
    rdy_cnt = 0; cs_ok = 1'b1; r_idx = -1; r_data = '0; s_rx = '0; timed_out = 1'b0;
    last_rise = -1; prev_sclk = a_sclk; done = 1'b0; c = 0;
    while (!done && c < 4000) begin
      @(negedge clk);
      c++;
      if (a_req_ready != 4'h0) begin
        rdy_cnt++;
        for (int i = 0; i < 4; i++) if (a_req_ready[i]) g_idx = i;
        if (auto_drop) a_req_valid = a_req_valid & ~a_req_ready;
      end
      if (a_rsp_valid != 4'h0) begin
        for (int i = 0; i < 4; i++) if (a_rsp_valid[i]) r_idx = i;
        r_data = a_rsp_data;
        s_rx   = slv_rx;
        if (a_cs_n !== 4'hF || a_busy !== 1'b0) cs_ok = 1'b0;
        done = 1'b1;
      end else if (&a_cs_n) begin
        if (g_idx < 0) pre_high++;
      end else begin
        cs_len++;
        if (g_idx < 0 || a_cs_n !== ~(4'b0001 << g_idx) || a_busy !== 1'b1) cs_ok = 1'b0;
      end
      if (a_sclk && !prev_sclk) begin
        rises++;
        if (last_rise >= 0) begin
          if (c - last_rise < per_min) per_min = c - last_rise;
          if (c - last_rise > per_max) per_max = c - last_rise;
        end
        last_rise = c;
      end
      prev_sclk = a_sclk;
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_req_valid = 4'h0; a_req_data = '0; b_req_valid = 4'h0; b_req_data = '0;
    miso_sel = 1'b0; slv_pat = '0;
    #12;
    n_checks++; if (a_cs_n !== 4'hF) begin n_errors++; $display("FAIL reset_cs_n: got %h want %h", a_cs_n, 4'hF); end
    n_checks++; if (a_sclk !== 1'b0) begin n_errors++; $display("FAIL reset_sclk: got %b want 0", a_sclk); end
    n_checks++; if (a_mosi !== 1'b0) begin n_errors++; $display("FAIL reset_mosi: got %b want 0", a_mosi); end
    n_checks++; if (a_req_ready !== 4'h0 || a_rsp_valid !== 4'h0) begin n_errors++; $display("FAIL reset_handshake: ready %h rsp %h want 0 0", a_req_ready, a_rsp_valid); end
    n_checks++; if (a_rsp_data !== 16'h0 || a_busy !== 1'b0) begin n_errors++; $display("FAIL reset_data_busy: data %h busy %b want 0000 0", a_rsp_data, a_busy); end
    n_checks++; if (b_cs_n !== 4'hF || b_busy !== 1'b0) begin n_errors++; $display("FAIL reset_b: cs_n %h busy %b want f 0", b_cs_n, b_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (a_cs_n !== 4'hF || a_busy !== 1'b0 || a_req_ready !== 4'h0) begin n_errors++; $display("FAIL idle_no_req: cs_n %h busy %b ready %h want f 0 0", a_cs_n, a_busy, a_req_ready); end
  endtask

  task automatic test_loopback();
    int g, ph, cl, ri, pmin, pmax, rc, ridx; bit ok, to;
    logic [15:0] rd, sx; exp_t e;
    miso_sel = 1'b0;
    a_req_data[15:0] = 16'hA55A;
    a_req_valid = 4'b0001;
    e.idx = 0; e.data = 16'hA55A; exp_q.push_back(e);
    observe_a(1'b1, g, ph, cl, ri, pmin, pmax, rc, ok, ridx, rd, sx, to);
    n_checks++; if (to) begin n_errors++; $display("FAIL lb_timeout: no completion within budget"); end
    n_checks++; if (g != 0 || rc != 1) begin n_errors++; $display("FAIL lb_ready: grant %0d pulses %0d want 0 1", g, rc); end
    n_checks++; if (cl != 133) begin n_errors++; $display("FAIL lb_cs_len: got %0d want 133", cl); end
    n_checks++; if (ri != 16 || pmin != 8 || pmax != 8) begin n_errors++; $display("FAIL lb_sclk: rises %0d period %0d..%0d want 16 8..8", ri, pmin, pmax); end
    n_checks++; if (!ok) begin n_errors++; $display("FAIL lb_cs_busy: cs/busy shape wrong got 0 want 1"); end
    e = exp_q.pop_front();
    n_checks++; if (ridx != e.idx || rd !== e.data) begin n_errors++; $display("FAIL lb_rsp: idx %0d data %h want %0d %h", ridx, rd, e.idx, e.data); end
  endtask

  task automatic test_miso_pattern();
    int g, ph, cl, ri, pmin, pmax, rc, ridx; bit ok, to;
    logic [15:0] rd, sx; exp_t e;
    miso_sel = 1'b1;
    slv_pat = 16'h3C0F;
    a_req_data[15:0] = 16'hFFFF;
    a_req_valid = 4'b0001;
    e.idx = 0; e.data = 16'h3C0F; exp_q.push_back(e);
    observe_a(1'b1, g, ph, cl, ri, pmin, pmax, rc, ok, ridx, rd, sx, to);
    e = exp_q.pop_front();
    n_checks++; if (to) begin n_errors++; $display("FAIL miso_timeout: no completion within budget"); end
    n_checks++; if (ridx != e.idx || rd !== e.data) begin n_errors++; $display("FAIL miso_rsp: idx %0d data %h want %0d %h", ridx, rd, e.idx, e.data); end
    n_checks++; if (sx !== 16'hFFFF) begin n_errors++; $display("FAIL miso_mosi_seen: got %h want ffff", sx); end
    miso_sel = 1'b0;
  endtask

  task automatic test_round_robin();
    int g, ph, cl, ri, pmin, pmax, rc, ridx; bit ok, to;
    logic [15:0] rd, sx; exp_t e;
    int order [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    a_req_data = 64'hD00D_C00C_B00B_A00A;
    a_req_valid = 4'b1111;
    for (int t = 0; t < 10; t++) begin
      if (t == 6) a_req_valid = 4'b1101;
      e.idx = order[t]; e.data = a_req_data[order[t]*16 +: 16]; exp_q.push_back(e);
      observe_a(1'b0, g, ph, cl, ri, pmin, pmax, rc, ok, ridx, rd, sx, to);
      e = exp_q.pop_front();
      n_checks++; if (to || g != e.idx) begin n_errors++; $display("FAIL rr_grant[%0d]: got %0d want %0d (timeout %0d)", t, g, e.idx, to); end
      n_checks++; if (ridx != e.idx || rd !== e.data) begin n_errors++; $display("FAIL rr_rsp[%0d]: idx %0d data %h want %0d %h", t, ridx, rd, e.idx, e.data); end
      if (t > 0) begin
        n_checks++; if (ph < 1) begin n_errors++; $display("FAIL rr_cs_gap[%0d]: got %0d want >=1", t, ph); end
      end
    end
    a_req_valid = 4'h0;
  endtask

  task automatic test_reset_mid_shift();
    int g, ph, cl, ri, pmin, pmax, rc, ridx; bit ok, to;
    logic [15:0] rd, sx; exp_t e;
    int rises, c; logic prev;
    a_req_data[15:0] = 16'h5AA5;
    a_req_valid = 4'b0001;
    rises = 0; c = 0; prev = a_sclk;
    while (rises < 5 && c < 2000) begin
      @(negedge clk); c++;
      if (a_sclk && !prev) rises++;
      prev = a_sclk;
    end
    n_checks++; if (rises < 5) begin n_errors++; $display("FAIL rst_reach_shift: rises %0d want 5", rises); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (a_cs_n !== 4'hF || a_sclk !== 1'b0 || a_busy !== 1'b0) begin n_errors++; $display("FAIL rst_async: cs_n %h sclk %b busy %b want f 0 0", a_cs_n, a_sclk, a_busy); end
    a_req_valid = 4'b0100;
    a_req_data[47:32] = 16'h6BD6;
    @(negedge clk); rst_n = 1'b1;
    e.idx = 2; e.data = 16'h6BD6; exp_q.push_back(e);
    observe_a(1'b1, g, ph, cl, ri, pmin, pmax, rc, ok, ridx, rd, sx, to);
    e = exp_q.pop_front();
    n_checks++; if (to || g != 2) begin n_errors++; $display("FAIL rst_regrant: got %0d want 2 (timeout %0d)", g, to); end
    n_checks++; if (cl != 133 || ri != 16) begin n_errors++; $display("FAIL rst_full_xfer: cs_len %0d rises %0d want 133 16", cl, ri); end
    n_checks++; if (ridx != e.idx || rd !== e.data) begin n_errors++; $display("FAIL rst_rsp: idx %0d data %h want %0d %h", ridx, rd, e.idx, e.data); end
  endtask

  task automatic test_back_to_back();
    int g, ph, cl, ri, pmin, pmax, rc, ridx; bit ok, to;
    logic [15:0] rd, sx; exp_t e;
    a_req_data[63:48] = 16'hC3A1;
    a_req_valid = 4'b1000;
    e.idx = 3; e.data = 16'hC3A1; exp_q.push_back(e);
    observe_a(1'b0, g, ph, cl, ri, pmin, pmax, rc, ok, ridx, rd, sx, to);
    e = exp_q.pop_front();
    n_checks++; if (to || g != 3 || ridx != e.idx || rd !== e.data) begin n_errors++; $display("FAIL b2b_first: grant %0d idx %0d data %h want 3 %0d %h", g, ridx, rd, e.idx, e.data); end
    a_req_data[63:48] = 16'h7E42;
    e.idx = 3; e.data = 16'h7E42; exp_q.push_back(e);
    observe_a(1'b0, g, ph, cl, ri, pmin, pmax, rc, ok, ridx, rd, sx, to);
    a_req_valid = 4'h0;
    e = exp_q.pop_front();
    n_checks++; if (to || g != 3 || ridx != e.idx || rd !== e.data) begin n_errors++; $display("FAIL b2b_second: grant %0d idx %0d data %h want 3 %0d %h", g, ridx, rd, e.idx, e.data); end
    n_checks++; if (ph != 1) begin n_errors++; $display("FAIL b2b_idle_gap: got %0d want 1", ph); end
    n_checks++; if (!ok) begin n_errors++; $display("FAIL b2b_done_cs: cs/busy shape wrong got 0 want 1"); end
  endtask

  task automatic test_corner();
    int c, cl, ri, last, pmin, pmax; bit done; logic prev;
    logic [3:0] rv, rd; exp_t e;
    b_req_data = 16'h0009;
    b_req_valid = 4'b0001;
    e.idx = 0; e.data = 16'h0009; exp_q.push_back(e);
    c = 0; cl = 0; ri = 0; last = -1; pmin = 1000000; pmax = 0; done = 1'b0;
    prev = b_sclk; rv = '0; rd = '0;
    while (!done && c < 500) begin
      @(negedge clk); c++;
      if (b_req_ready != 4'h0) b_req_valid = b_req_valid & ~b_req_ready;
      if (b_cs_n[0] === 1'b0) cl++;
      if (b_sclk && !prev) begin
        ri++;
        if (last >= 0) begin
          if (c - last < pmin) pmin = c - last;
          if (c - last > pmax) pmax = c - last;
        end
        last = c;
      end
      prev = b_sclk;
      if (b_rsp_valid != 4'h0) begin rv = b_rsp_valid; rd = b_rsp_data; done = 1'b1; end
    end
    e = exp_q.pop_front();
    n_checks++; if (!done) begin n_errors++; $display("FAIL corner_timeout: no completion within budget"); end
    n_checks++; if (cl != 11) begin n_errors++; $display("FAIL corner_cs_len: got %0d want 11", cl); end
    n_checks++; if (ri != 4 || pmin != 2 || pmax != 2) begin n_errors++; $display("FAIL corner_sclk: rises %0d period %0d..%0d want 4 2..2", ri, pmin, pmax); end
    n_checks++; if (rv !== 4'b0001 || {12'h000, rd} !== e.data) begin n_errors++; $display("FAIL corner_rsp: valid %b data %h want 0001 %h", rv, rd, e.data); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_miso_pattern();
    test_round_robin();
    test_reset_mid_shift();
    test_back_to_back();
    test_corner();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_xfer_sched.md
Name: spi_xfer_sched

Overview:
Shares one SPI bus between NREQ fabric requesters on the MicroZed PL.
- Round-robin arbitration between requesters.
- Per-requester chip-select sequencing.
- SCLK generation from axi_aclk.
- Full-duplex shift of one DWIDTH-bit word per grant.
- Runs in the PS-supplied axi_aclk domain. Read data returns to the granted requester.

Parameters:
NREQ, 4, number of requesters and chip selects (2..8)
DWIDTH, 16, bits per transfer (4..32)
CLKDIV, 4, axi_aclk cycles per SCLK half-period (>=1)
CS_GAP, 2, cycles CS is asserted before first SCLK edge and after last edge (>=1)

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester transfer request
req_data  in  NREQ*DWIDTH  write word; requester i uses slice [i*DWIDTH +: DWIDTH]
req_ready  out  NREQ  one-cycle accept pulse to the granted requester
rsp_valid  out  NREQ  one-cycle completion pulse to the requester that owned the transfer
rsp_data  out  DWIDTH  received word; valid when any rsp_valid bit is high
busy  out  1  high from grant through completion
spi_sclk  out  1  SPI clock, mode 0 (idle low)
spi_mosi  out  1  master out, MSB first
spi_miso  in  1  master in
spi_cs_n  out  NREQ  active-low chip selects, one-hot-low when active

Behaviour:
- Reset values (asynchronous, immediate, including mid-transfer):
  - spi_cs_n all 1; spi_sclk 0; spi_mosi 0
  - req_ready 0; rsp_valid 0; rsp_data 0; busy 0
  - state IDLE; round-robin pointer 0
- After release, the first grant is evaluated on the first axi_aclk edge with reset high.
- All outputs are registered.
- FSM states: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE:
  - If any req_valid, grant winner g: the first asserted index starting at ptr, wrapping modulo NREQ.
  - Same edge: req_ready[g]=1 for exactly one cycle; latch req_data slice g into shift register; ptr <= (g+1) mod NREQ; busy=1; spi_cs_n[g]=0; spi_mosi=MSB; go to SETUP.
  - No valid: remain in IDLE, outputs idle.
- SETUP: hold for CS_GAP cycles (SCLK low), then go to SHIFT.
- SHIFT: DWIDTH bit periods, each CLKDIV cycles SCLK low followed by CLKDIV cycles SCLK high.
  - spi_miso is sampled into the shift register LSB on the cycle SCLK rises.
  - spi_mosi advances to the next bit on the cycle SCLK falls.
  - No mosi change after the final high phase; SCLK returns low and the FSM goes to HOLD.
- HOLD: CS_GAP cycles with CS still low, SCLK low.
- DONE (1 cycle):
  - spi_cs_n all 1; rsp_valid[g]=1; rsp_data=received word; busy=0.
  - Next cycle: IDLE. This guarantees >=1 cycle with CS high between transfers, even for back-to-back requests.
- Active-CS time per transfer = 1 + CS_GAP + 2*CLKDIV*DWIDTH + CS_GAP cycles. The leading 1 is the grant cycle.
- req_valid changes after grant are ignored until IDLE.
- req_valid dropping without ready: no side effects.
- Simultaneous requests: strictly round-robin; no requester waits more than NREQ-1 transfers.
- rsp_data holds its value until the next DONE.

Decomposition:
- Package spi_xfer_pkg holds:
  - state enum type (IDLE, SETUP, SHIFT, HOLD, DONE)
  - width helper constants for the counters: $clog2(NREQ), $clog2(DWIDTH+1), $clog2(max(CLKDIV,CS_GAP)+1)
- Sub-module rr_arbiter (parameter NREQ): inputs req vector, ptr, enable; outputs one-hot grant and encoded index. Purely combinational; ptr register lives in the top FSM.

Test Plan:
1. Single loopback transfer (mosi tied to miso), NREQ=4, DWIDTH=16, CLKDIV=4, CS_GAP=2, req_valid=0001, data 0xA55A:
   - req_ready[0] pulses once.
   - spi_cs_n[0] low exactly 133 cycles.
   - 16 SCLK rising edges, period 8 cycles.
   - rsp_valid[0] pulses with rsp_data=0xA55A.
2. MISO pattern: miso driven by a model returning 0x3C0F, mosi word 0xFFFF:
   - rsp_data=0x3C0F.
   - mosi sampled by the model on rising edges = 0xFFFF.
3. Round-robin: req_valid=1111 held continuously:
   - Grant order 0,1,2,3,0,1.
   - Each CS high >=1 cycle between transfers.
   - Then drop req 1 only: order continues 2,3,0,2.
4. Reset mid-SHIFT: assert axi_aresetn low after 5 SCLK edges:
   - spi_cs_n=1111, spi_sclk=0, busy=0 without waiting for a clock edge.
   - After release with req_valid=0100, grant goes to 2 (ptr restarted at 0) and the full transfer completes.
5. Corner: CLKDIV=1, CS_GAP=1, DWIDTH=4, loopback data 0x9:
   - SCLK period 2 cycles.
   - cs_n low 11 cycles.
   - rsp_data=0x9.
6. Back-to-back same requester: req_valid[3] held high, data updated after each req_ready:
   - Two transfers with exactly one CS-high cycle between them (DONE), plus the IDLE grant cycle.
   - rsp_data matches each word in turn.
